// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with word-by-word line refill.
// Latency: hits are combinational from inst_addr. A miss stalls for LINE_WORDS+1 cycles plus one cycle per mem_ack=0 cycle.
// Backpressure: the core holds pc while inst_stall=1. Refill requests wait on mem_ack indefinitely.
// Ports: clk/rst_b (async active-low); inst_addr -> inst/inst_stall (fetch side);
//        flush (invalidate all); mem_req/mem_req_addr -> mem_ack/mem_rdata (refill side).
module icache #(
  parameter int XLEN       = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] inst_addr,
  output logic [XLEN-1:0] inst,
  output logic            inst_stall,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int WW  = $clog2(LINE_WORDS);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int WLO = 2;
  localparam int ILO = WLO + WW;
  localparam int TLO = ILO + IW;
  localparam int TW  = XLEN - TLO;
  localparam logic [WW-1:0] LAST = WW'(LINE_WORDS - 1);

  typedef enum logic {LOOKUP, REFILL} state_t;

  state_t state, state_nxt;

  logic [WW-1:0]   cnt;
  logic            flush_pend;
  logic [XLEN-1:0] base;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]   tag_arr  [NUM_LINES];
  logic [XLEN-1:0] data_arr [NUM_LINES][LINE_WORDS];

  // Fetch address split; the byte offset is not needed for word fetches.
  logic [WW-1:0] word;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          unused_offset;

  assign word          = inst_addr[ILO-1:WLO];
  assign idx           = inst_addr[TLO-1:ILO];
  assign tag           = inst_addr[XLEN-1:TLO];
  assign unused_offset = ^inst_addr[1:0];

  // Refill target comes from the latched base, not the live address.
  logic [IW-1:0] ref_idx;
  logic [TW-1:0] ref_tag;
  assign ref_idx = base[TLO-1:ILO];
  assign ref_tag = base[XLEN-1:TLO];

  logic hit;
  logic miss;
  logic wr_word;
  logic line_done;

  assign hit       = (state == LOOKUP) && valid[idx] && (tag_arr[idx] == tag);
  assign miss      = (state == LOOKUP) && !hit;
  assign wr_word   = (state == REFILL) && mem_ack;
  assign line_done = wr_word && (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= LOOKUP;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOOKUP:  if (miss)      state_nxt = REFILL;
      REFILL:  if (line_done) state_nxt = LOOKUP;
      default: state_nxt = LOOKUP;
    endcase
  end

  // Output logic
  always_comb begin
    inst         = '0;
    inst_stall   = 1'b1;
    mem_req      = 1'b0;
    mem_req_addr = '0;
    if (hit) begin
      inst       = data_arr[idx][word];
      inst_stall = 1'b0;
    end
    if (state == REFILL) begin
      mem_req      = 1'b1;
      mem_req_addr = base | (XLEN'(cnt) << 2);
    end
  end

  // Refill bookkeeping and valid bits
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt        <= '0;
      flush_pend <= 1'b0;
      base       <= '0;
      valid      <= '0;
    end else begin
      if (miss) begin
        base       <= {inst_addr[XLEN-1:ILO], {ILO{1'b0}}};
        cnt        <= '0;
        flush_pend <= 1'b0;
      end
      if (wr_word) cnt <= cnt + 1'b1;
      if (state == REFILL && flush) flush_pend <= 1'b1;

      // A flush on the final ack still wins: the line stays invalid.
      if (flush)
        valid <= '0;
      else if (line_done && !flush_pend)
        valid[ref_idx] <= 1'b1;
    end
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_word)   data_arr[ref_idx][cnt] <= mem_rdata;
    if (line_done) tag_arr[ref_idx]       <= ref_tag;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between `mips_core`'s fetch port (`inst_addr`/`inst`) and the instruction memory. Hits return the instruction combinationally in the same cycle. A miss raises `inst_stall`, and the core holds `pc` while it is high. During a miss, a small FSM refills one line word-by-word over a request/acknowledge memory interface.

## Interface
- `XLEN`, 32: address and data width.
- `LINE_WORDS`, 4: 32-bit words per line; power of 2, ≥2.
- `NUM_LINES`, 16: number of lines; power of 2.
- `clk`  in  1  rising-edge clock.
- `rst_b`  in  1  reset; one clock, asynchronous and active-low.
- `inst_addr`  in  XLEN  fetch byte address from the core; bits [1:0] ignored.
- `inst`  out  XLEN  instruction word; valid when `inst_stall`=0.
- `inst_stall`  out  1  high while the addressed word is unavailable.
- `flush`  in  1  single-cycle pulse that invalidates all lines.
- `mem_req`  out  1  refill word request.
- `mem_req_addr`  out  XLEN  word-aligned address of the requested word.
- `mem_ack`  in  1  `mem_rdata` is valid this cycle for `mem_req_addr`.
- `mem_rdata`  in  XLEN  refill data.

## Operation
- Address split:
  - offset = `inst_addr[1:0]`, ignored.
  - word = next log2(`LINE_WORDS`) bits.
  - index = next log2(`NUM_LINES`) bits.
  - tag = the remaining upper bits.
  - Defaults: word = [3:2], index = [7:4], tag = [31:8].
- Storage per line: valid bit, tag, `LINE_WORDS` data words.
- Hit = valid[index] && tag match && state==LOOKUP.
  - On a hit: `inst` = data[index][word], `inst_stall`=0.
  - Otherwise: `inst`=0, `inst_stall`=1.
- FSM states: LOOKUP, REFILL.
  - LOOKUP, miss: latch line base (`inst_addr` with word and offset bits zeroed), set `cnt`=0, clear `flush_pend`, go to REFILL.
  - REFILL: `mem_req`=1, `mem_req_addr` = base + 4·`cnt`.
  - REFILL, `mem_ack`=1: write `mem_rdata` into data[base index][cnt] and increment `cnt`.
  - REFILL, ack on `cnt`==`LINE_WORDS`-1: write the tag; set valid unless `flush_pend`; return to LOOKUP.
  - REFILL, `mem_ack`=0: hold `cnt`, `mem_req`, and `mem_req_addr`; the requester waits with no timeout.
- Words always refill in order 0..`LINE_WORDS`-1; there is no critical-word-first.
- A refill overwrites the line in place. Conflicting tags evict the previous occupant.
- `flush` handling:
  - In LOOKUP: all valid bits clear at the next edge. A hit in the same cycle as `flush` is still served.
  - In REFILL: all valid bits clear, `flush_pend` is set, and the refill finishes without setting valid. The next lookup then misses again.
- If `inst_addr` changes during REFILL, the latched line still completes. The new address is looked up afterwards.
- `mem_ack` while in LOOKUP is ignored.

## Timing
- Reset (async, `rst_b`=0):
  - All valid bits 0, state LOOKUP, `cnt`=0, `flush_pend`=0.
  - `mem_req`=0, `mem_req_addr`=0.
  - Outputs during reset: `inst`=0, `inst_stall`=1 (since nothing is valid).
  - Data and tag arrays are not reset.
- Reset asserted mid-refill abandons the refill immediately. `mem_req` drops asynchronously, and the partial line stays invalid.
- Hit latency: 0 cycles, combinational from `inst_addr`.
- Miss penalty with `mem_ack` tied high:
  - Cycle 0: miss detected, `inst_stall`=1.
  - Cycles 1..`LINE_WORDS`: REFILL, one word per cycle.
  - Cycle `LINE_WORDS`+1: hit, `inst_stall`=0.
  - Total stall = `LINE_WORDS`+1 cycles (5 with defaults).
  - Each cycle with `mem_ack`=0 adds one stall cycle.
- `mem_req` and `mem_req_addr` are driven from registered state only, never combinationally from `inst_addr`.
- `inst_stall` is combinational from `inst_addr`, state, and the arrays.

## Test plan
- **Reset then cold miss:**
  - Stimulus: release `rst_b`; `inst_addr`=0x0; memory returns 0x11110000+n for word n with `mem_ack` always 1.
  - Required: `mem_req_addr` = 0x0, 0x4, 0x8, 0xC on consecutive cycles; `inst_stall` high 5 cycles; then `inst`=0x11110000.
- **Sequential hits:**
  - Stimulus: after the cold miss, `inst_addr` = 0x4, 0x8, 0xC.
  - Required: `inst_stall`=0 every cycle; `inst` = 0x11110001..03; `mem_req` stays 0.
- **Conflict eviction:**
  - Stimulus: fetch 0x100 (index 0, tag 1), then 0x0.
  - Required: each fetch refills (4 requests at 0x100..0x10C, then at 0x0..0xC); `inst` correct after each.
- **Acknowledge gaps:**
  - Stimulus: `mem_ack` pattern 1,0,0,1,1,0,1 during a refill of 0x40.
  - Required: `mem_req_addr` holds through each 0; stall lasts 8 cycles; data lands in the correct words.
- **Flush:**
  - Stimulus: `flush` pulse while line 0 is valid; then `flush` pulse during cycle 2 of a refill.
  - Required: the next fetch of 0x0 misses; after the mid-refill flush, the line completes, the same address misses again, and 4 new requests are issued.
- **Reset mid-refill:**
  - Stimulus: assert `rst_b`=0 after 2 acks, then release it and fetch the same address.
  - Required: `mem_req` is 0 during reset; the fetch misses and requests restart at word 0.
